vec_gen_sched: RTL and testbench

- Round-robin scheduler that shares one vec_generator instance between two requesters.
- Each requester submits a (mode, idx) job. The block latches it, then pulses the generator's active-low reset when the mode differs from the previous job.
- It then issues a one-cycle start, streams the serial vector bits back tagged with the owner, and returns a done pulse on finish.
- Sits between the signature-generation control FSMs and vec_generator.

---
 rtl/vec_gen_sched_pkg.sv | 5 +
 rtl/vec_gen_sched_rr_arb2.sv | 10 +
 rtl/vec_gen_sched.sv | 168 ++++++++++++++++
 tb/tb_vec_gen_sched.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/vec_gen_sched_pkg.sv
// vec_gen_sched_pkg: shared state encoding and default index width for vec_gen_sched
package vec_gen_sched_pkg;
  localparam int IDX_W_DEF = 14;
  typedef enum logic [2:0] {S_IDLE, S_VRST, S_START, S_RUN, S_DONE} vgs_state_e;
endpackage

// File: rtl/vec_gen_sched_rr_arb2.sv
// vgs_rr_arb2: two-way round-robin arbiter, rr_ptr_i picks the winner on a tie
module vgs_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic       gid_o,
  output logic       gvld_o
);
  assign gvld_o = |req_i;
  assign gid_o  = &req_i ? rr_ptr_i : req_i[1];
endmodule

// File: rtl/vec_gen_sched.sv
// vec_gen_sched: round-robin sharing of one vec_generator between two requesters (optional watchdog: VGS_WATCHDOG_EN)
module vec_gen_sched
  import vec_gen_sched_pkg::*;
#(
  parameter int IDX_W      = IDX_W_DEF,
  parameter int VG_RST_CYC = 2,
  parameter int WD_LIMIT   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             mode0,
  input  logic [IDX_W-1:0] idx0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic             mode1,
  input  logic [IDX_W-1:0] idx1,
  output logic             gnt1,
  output logic             done1,
  output logic             vg_rst_b,
  output logic             vg_start,
  output logic             vg_mode,
  output logic [IDX_W-1:0] vg_idx,
  input  logic             vg_finish,
  input  logic             vg_vector,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             bit_owner,
  output logic             busy,
  output logic             wd_err
);
  if (VG_RST_CYC < 1 || VG_RST_CYC > 15 || WD_LIMIT < 2) begin : g_bad_cfg
    $error("vec_gen_sched: VG_RST_CYC must be 1..15 and WD_LIMIT at least 2");
  end
  vgs_state_e       state_q, state_d;
  logic [3:0]       vcnt_q, vcnt_d;
  logic             mode_vld_q, mode_vld_d;
  logic             last_mode_q, last_mode_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             owner_q, owner_d;
  logic             vg_mode_q, vg_mode_d;
  logic [IDX_W-1:0] vg_idx_q, vg_idx_d;
  logic [1:0]       gnt_q, gnt_d, done_q, done_d;
  logic             vg_rst_b_q, vg_rst_b_d, vg_start_q, vg_start_d;
  logic             bit_valid_q, bit_valid_d, bit_out_q, bit_out_d, bit_owner_q, bit_owner_d;
  logic             busy_q, busy_d;
  logic             gid, gvld, grab, wd_fire;
  vgs_rr_arb2 u_arb (
    .req_i   ({req1, req0}),
    .rr_ptr_i(rr_ptr_q),
    .gid_o   (gid),
    .gvld_o  (gvld)
  );
  // a watchdog done pulse lands in IDLE; hold off a new grant until it has gone
  assign grab = state_q == S_IDLE && gvld && !(|done_q);
`ifdef VGS_WATCHDOG_EN
  localparam int WCW = $clog2(WD_LIMIT) + 1;
  logic [WCW-1:0] wcnt_q;
  logic           wd_err_q;
  assign wd_fire = state_q == S_RUN && !vg_finish && wcnt_q == WCW'(WD_LIMIT - 1);
  // count RUN cycles and keep a watchdog expiry until reset
  always_ff @(posedge clk) begin
    wcnt_q   <= (rst || state_q != S_RUN) ? '0 : wcnt_q + 1'b1;
    wd_err_q <= !rst && (wd_err_q || wd_fire);
  end
  assign wd_err = wd_err_q;
`else
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vcnt_q      <= '0;
      mode_vld_q  <= 1'b0;
      last_mode_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      vg_mode_q   <= 1'b0;
      vg_idx_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      vg_rst_b_q  <= 1'b0;
      vg_start_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_owner_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vcnt_q      <= vcnt_d;
      mode_vld_q  <= mode_vld_d;
      last_mode_q <= last_mode_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      vg_mode_q   <= vg_mode_d;
      vg_idx_q    <= vg_idx_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      vg_rst_b_q  <= vg_rst_b_d;
      vg_start_q  <= vg_start_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      bit_owner_q <= bit_owner_d;
      busy_q      <= busy_d;
    end
  end
  // job sequencing: grant and latch, optional generator reset, start, run, done
  always_comb begin
    state_d     = state_q;
    vcnt_d      = '0;
    mode_vld_d  = mode_vld_q;
    last_mode_d = last_mode_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    vg_mode_d   = vg_mode_q;
    vg_idx_d    = vg_idx_q;
    case (state_q)
      S_IDLE: if (grab) begin
        owner_d   = gid;
        rr_ptr_d  = !gid;
        vg_mode_d = gid ? mode1 : mode0;
        vg_idx_d  = gid ? idx1 : idx0;
        state_d   = (!mode_vld_q || vg_mode_d != last_mode_q) ? S_VRST : S_START;
      end
      S_VRST: begin
        vcnt_d = vcnt_q + 4'd1;
        if (vcnt_q == 4'(VG_RST_CYC - 1)) begin
          state_d     = S_START;
          vcnt_d      = '0;
          last_mode_d = vg_mode_q;
          mode_vld_d  = 1'b1;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        state_d    = vg_finish ? S_DONE : wd_fire ? S_IDLE : S_RUN;
        mode_vld_d = mode_vld_q && !wd_fire;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // next values of the registered outputs, decoded from the upcoming state
  always_comb begin
    gnt_d       = (state_d inside {S_VRST, S_START, S_RUN}) ? {owner_d, !owner_d} : 2'b00;
    done_d      = (state_d == S_DONE || wd_fire) ? {owner_q, !owner_q} : 2'b00;
    vg_rst_b_d  = state_d == S_VRST ? 1'b0 : state_d == S_IDLE ? mode_vld_d : 1'b1;
    vg_start_d  = state_d == S_START;
    bit_valid_d = state_q == S_RUN && !vg_finish;
    bit_out_d   = bit_valid_d && vg_vector;
    bit_owner_d = bit_valid_d && owner_q;
    busy_d      = state_d != S_IDLE;
  end
  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign vg_rst_b  = vg_rst_b_q;
  assign vg_start  = vg_start_q;
  assign vg_mode   = vg_mode_q;
  assign vg_idx    = vg_idx_q;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_out_q;
  assign bit_owner = bit_owner_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_vec_gen_sched.sv
// tb_vec_gen_sched: job-level reference model of vec_gen_sched driven with randomized jobs
module tb_vec_gen_sched;
  localparam int IW  = 14;
  localparam int RC  = 2;
  localparam int WDL = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, mode0 = 0, req1 = 0, mode1 = 0;
  logic [IW-1:0] idx0 = '0, idx1 = '0;
  logic gnt0, done0, gnt1, done1, vg_rst_b, vg_start, vg_mode;
  logic [IW-1:0] vg_idx;
  logic vg_finish = 0, vg_vector = 0;
  logic bit_valid, bit_out, bit_owner, busy, wd_err;
  int checks = 0, errors = 0;
  bit m_vld = 0, m_last = 0, m_rr = 0;
  vec_gen_sched #(.IDX_W(IW), .VG_RST_CYC(RC), .WD_LIMIT(WDL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .mode0(mode0), .idx0(idx0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .mode1(mode1), .idx1(idx1), .gnt1(gnt1), .done1(done1),
    .vg_rst_b(vg_rst_b), .vg_start(vg_start), .vg_mode(vg_mode), .vg_idx(vg_idx),
    .vg_finish(vg_finish), .vg_vector(vg_vector),
    .bit_valid(bit_valid), .bit_out(bit_out), .bit_owner(bit_owner),
    .busy(busy), .wd_err(wd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // one job from request to done; rst_at aborts with reset after that bit, hang withholds finish
  task automatic job(input bit r0, input bit r1, input bit m0, input bit m1,
                     input logic [IW-1:0] i0, input logic [IW-1:0] i1,
                     input int nb, input int rst_at, input bit hang);
    bit w, md, vr, b;
    logic [IW-1:0] ix;
    logic [1:0] oh;
    req0 = r0; req1 = r1; mode0 = m0; mode1 = m1; idx0 = i0; idx1 = i1;
    w  = (r0 && r1) ? m_rr : r1;
    md = w ? m1 : m0;
    ix = w ? i1 : i0;
    oh = w ? 2'b10 : 2'b01;
    vr = !m_vld || md != m_last;
    m_rr = !w;
    tick();
    chk("grant", {gnt1, gnt0}, oh);
    chk("busy_on", busy, 1);
    chk("vg_idx", vg_idx, ix);
    chk("vg_mode", vg_mode, md);
    if (w) begin mode1 = !m1; idx1 = IW'($urandom); end
    else begin mode0 = !m0; idx0 = IW'($urandom); end
    if (vr) for (int k = 0; k < RC; k++) begin
      chk("vrst_low", vg_rst_b, 0);
      chk("vrst_nostart", vg_start, 0);
      tick();
    end
    m_vld = 1; m_last = md;
    chk("start", vg_start, 1);
    chk("rst_b_high", vg_rst_b, 1);
    chk("idx_latched", vg_idx, ix);
    chk("mode_latched", vg_mode, md);
    vg_finish = 1'($urandom_range(0, 1));
    tick();
    chk("start_once", vg_start, 0);
    if (w) req1 = 1'($urandom_range(0, 1)); else req0 = 1'($urandom_range(0, 1));
    for (int k = 0; k < nb; k++) begin
      b = 1'($urandom_range(0, 1));
      vg_vector = b; vg_finish = 0;
      if (k == rst_at) rst = 1;
      tick();
      if (k == rst_at) begin
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_bv", bit_valid, 0);
        chk("rst_rst_b", vg_rst_b, 0);
        chk("rst_busy", busy, 0);
        rst = 0; req0 = 0; req1 = 0;
        m_vld = 0; m_rr = 0;
        return;
      end
      chk("bit_valid", bit_valid, 1);
      chk("bit_out", bit_out, b);
      chk("bit_owner", bit_owner, w);
      chk("gnt_hold", {gnt1, gnt0}, oh);
    end
    if (hang) begin
      chk("wd_done", {done1, done0}, oh);
      chk("wd_err_set", wd_err, 1);
      chk("wd_gnt_off", {gnt1, gnt0}, 0);
      chk("wd_rst_b", vg_rst_b, 0);
      chk("wd_idle", busy, 0);
      m_vld = 0;
      if (w) req1 = 0; else req0 = 0;
      tick();
      chk("wd_done_once", {done1, done0}, 0);
      chk("wd_err_sticky", wd_err, 1);
      return;
    end
    vg_finish = 1; vg_vector = 1'($urandom);
    tick();
    chk("done", {done1, done0}, oh);
    chk("gnt_off", {gnt1, gnt0}, 0);
    chk("bv_off", bit_valid, 0);
    vg_finish = 0;
    if (w) req1 = 0; else req0 = 0;
    tick();
    chk("done_once", {done1, done0}, 0);
    chk("busy_off", busy, 0);
  endtask
  initial begin
    logic [1:0] r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt0", {gnt1, gnt0}, 0);
    chk("rst_vg_rst_b", vg_rst_b, 0);
    chk("rst_vg_start", vg_start, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_wd_err", wd_err, 0);
    rst = 0;
    tick();
    chk("idle_held", vg_rst_b, 0);
    job(1, 0, 0, 0, 14'd100, 14'd0, 4, -1, 0);
    job(1, 0, 0, 0, 14'd120, 14'd0, 3, -1, 0);
    job(0, 1, 0, 1, 14'd0, 14'd980, 5, -1, 0);
    for (int j = 0; j < 3; j++) job(1, 1, 0, 1, 14'd9799, 14'd980, $urandom_range(0, 5), -1, 0);
    for (int j = 0; j < 12; j++) begin
      r = 2'($urandom_range(1, 3));
      job(r[0], r[1], 1'($urandom), 1'($urandom), IW'($urandom), IW'($urandom),
          $urandom_range(0, 6), -1, 0);
    end
    job(1, 0, 1, 0, 14'd77, 14'd0, 6, 2, 0);
    job(1, 0, m_last, 0, 14'd78, 14'd0, 2, -1, 0);
`ifdef VGS_WATCHDOG_EN
    job(0, 1, 0, 1, 14'd0, 14'd555, WDL, -1, 1);
    job(1, 0, 0, 0, 14'd321, 14'd0, 2, -1, 0);
    chk("wd_err_kept", wd_err, 1);
    rst = 1;
    tick();
    rst = 0;
    m_vld = 0; m_rr = 0;
    chk("wd_err_clear", wd_err, 0);
`else
    chk("wd_err_tied", wd_err, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
